fg_cfg_ctrl: RTL and testbench
==============================

// Module: fg_cfg_ctrl
// PURPOSE
//  Front-panel configuration controller for the function generator. Turns raw
//  button levels into edited waveform/period/amplitude selections held in shadow
//  registers. Commits them to the live registers driving the waveform datapath
//  only at a waveform-cycle boundary (wrap) or on explicit apply. This keeps
//  output glitch-free when settings change.
// PARAMETERS
//  REPEAT_DLY   50_000_000  cycles inc/dec must be held before auto-repeat starts
//  REPEAT_RATE  10_000_000  cycles between auto-repeat steps once repeating
//  NUM_PERIOD   4           number of period settings; peri_sel range 0..NUM_PERIOD-1
//  NUM_AMP      8           number of amplitude settings; amp_sel range 0..NUM_AMP-1
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  btn        in   4  debounced button levels: [0] apply, [1] inc, [2] dec, [3] mode
//  wrap       in   1  1-cycle pulse from waveform datapath at phase wrap
//  wave_sel   out  2  live waveform: 0 sine, 1 square, 2 triangle, 3 sawtooth
//  peri_sel   out  3  live period index
//  amp_sel    out  3  live amplitude index
//  cfg_upd    out  1  1-cycle pulse in the cycle after the live registers change
//  edit_mode  out  2  field being edited: 0 WAVE, 1 PERIOD, 2 AMP
//  pending    out  1  shadow differs from live, awaiting commit
// BEHAVIOUR
//  Reset (async, any time): outputs are all zero.
//   - Mode FSM returns to WAVE.
//   - Shadow registers are 0; repeat counters are cleared.
//   - Any commit in flight is dropped.
//  Edge detect: each btn bit is registered once. An event is btn & ~btn_q, giving
//   1 cycle of latency from a btn rising edge to its action.
//  Mode FSM: on a btn[3] event the edit mode steps WAVE->PERIOD->AMP->WAVE.
//   edit_mode updates on that edge.
//  Inc/dec act on the shadow register of the current edit_mode:
//   - WAVE: wraps modulo 4.
//   - PERIOD: wraps; NUM_PERIOD-1 +1 gives 0, and 0 -1 gives NUM_PERIOD-1.
//   - AMP: saturates at 0 and NUM_AMP-1. A saturated step is a no-op and does
//     not set pending.
//  Auto-repeat: while inc (or dec) stays high, the hold counter counts from the
//   edge event.
//   - At REPEAT_DLY a step fires, then every REPEAT_RATE cycles after that.
//   - Release clears the counter.
//  Simultaneous events:
//   - inc and dec in the same cycle, as events or both held: no step, and the
//     counter is cleared.
//   - mode and inc/dec in the same cycle: the step applies to the OLD mode, then
//     the mode advances.
//  pending: set in the cycle after any shadow change (live != shadow);
//   cleared on commit.
//  Commit happens when (wrap & pending) or a btn[0] event (apply works even
//   if pending=0).
//   - Live registers take the shadow values as registered at that edge.
//   - cfg_upd pulses in the next cycle.
//   - A shadow change in the same cycle as the commit is not included. It
//     re-sets pending and waits for the next wrap.
//  Consecutive wraps with pending=0 produce no cfg_upd. wrap is never assumed to
//   be single-cycle-separated from apply; apply plus wrap in one cycle gives one
//   commit and one cfg_upd.
//  Counters are sized to fit REPEAT_DLY/REPEAT_RATE and must never overflow
//   while a button is held indefinitely.
// TESTING
//  1 rst high mid-edit (pending=1, mode=AMP): all outputs 0 immediately, no
//    cfg_upd after release.
//  2 mode=PERIOD, 5 inc events -> shadow 1,2,3,0,1. Then a wrap pulse -> peri_sel=1
//    and one cfg_upd, pending=0.
//  3 mode=AMP, 10 inc events -> shadow saturates at 7. Then 1 dec -> 6. No wrap yet:
//    amp_sel stays 0, pending=1.
//  4 inc held 2*REPEAT_DLY (small params, e.g. DLY=8, RATE=4): steps at edge,
//    +8, then every 4 cycles. inc+dec held together -> no steps.
//  5 wave inc in the same cycle as wrap with pending=0 -> no commit. Next wrap ->
//    wave_sel=1 and cfg_upd.
//  6 btn[0] event with no wrap -> commit within 2 cycles. Mode+inc in the same
//    cycle -> old field incremented, edit_mode advanced.

Source files
------------

// File: rtl/fg_cfg_ctrl_if.sv
// Front-panel button/wrap inputs and live configuration outputs of the
// function-generator configuration controller.
interface fg_cfg_ctrl_if;
    logic [3:0] btn;
    logic       wrap;
    logic [1:0] wave_sel;
    logic [2:0] peri_sel;
    logic [2:0] amp_sel;
    logic       cfg_upd;
    logic [1:0] edit_mode;
    logic       pending;

    modport master (
        output btn, wrap,
        input  wave_sel, peri_sel, amp_sel, cfg_upd, edit_mode, pending
    );

    modport slave (
        input  btn, wrap,
        output wave_sel, peri_sel, amp_sel, cfg_upd, edit_mode, pending
    );
endinterface

// File: rtl/fg_cfg_ctrl.sv
// Front-panel configuration controller: edits shadow waveform/period/amplitude
// selections and commits them to the live registers at a wrap or on apply.
module fg_cfg_ctrl #(
    parameter int unsigned REPEAT_DLY  = 50_000_000,
    parameter int unsigned REPEAT_RATE = 10_000_000,
    parameter int unsigned NUM_PERIOD  = 4,
    parameter int unsigned NUM_AMP     = 8
) (
    input logic          clk,
    input logic          rst,
    fg_cfg_ctrl_if.slave cfg
);
    localparam int unsigned WAVE_W  = 2;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned BTN_W   = 4;
    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        MODE_WAVE   = 2'd0,
        MODE_PERIOD = 2'd1,
        MODE_AMP    = 2'd2
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [BTN_W-1:0]   btn_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rep_q, rep_d;
    logic [WAVE_W-1:0]  sh_wave_q, sh_wave_d, wave_q, wave_d;
    logic [SEL_W-1:0]   sh_peri_q, sh_peri_d, peri_q, peri_d;
    logic [SEL_W-1:0]   sh_amp_q, sh_amp_d, amp_q, amp_d;
    logic               cfg_upd_q, cfg_upd_d;
    logic               pending_q, pending_d;

    logic [BTN_W-1:0]   ev;
    logic               step_inc, step_dec, commit;

    always_comb begin
        ev        = cfg.btn & ~btn_q;
        step_inc  = 1'b0;
        step_dec  = 1'b0;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        mode_d    = mode_q;
        sh_wave_d = sh_wave_q;
        sh_peri_d = sh_peri_q;
        sh_amp_d  = sh_amp_q;

        // Hold/auto-repeat: opposing or released buttons cancel the hold.
        if (cfg.btn[1] == cfg.btn[2]) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (ev[1] || ev[2]) begin
            step_inc = ev[1];
            step_dec = ev[2];
            cnt_d    = '0;
            rep_d    = 1'b0;
        end else if ((!rep_q && cnt_q == CNT_W'(REPEAT_DLY - 1)) ||
                     (rep_q && cnt_q == CNT_W'(REPEAT_RATE - 1))) begin
            step_inc = cfg.btn[1];
            step_dec = cfg.btn[2];
            cnt_d    = '0;
            rep_d    = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (mode_q)
            MODE_WAVE: begin
                if (step_inc)      sh_wave_d = sh_wave_q + WAVE_W'(1);
                else if (step_dec) sh_wave_d = sh_wave_q - WAVE_W'(1);
            end
            MODE_PERIOD: begin
                if (step_inc)
                    sh_peri_d = (sh_peri_q == SEL_W'(NUM_PERIOD - 1)) ? '0 : sh_peri_q + SEL_W'(1);
                else if (step_dec)
                    sh_peri_d = (sh_peri_q == '0) ? SEL_W'(NUM_PERIOD - 1) : sh_peri_q - SEL_W'(1);
            end
            MODE_AMP: begin
                if (step_inc && sh_amp_q != SEL_W'(NUM_AMP - 1)) sh_amp_d = sh_amp_q + SEL_W'(1);
                else if (step_dec && sh_amp_q != '0)           sh_amp_d = sh_amp_q - SEL_W'(1);
            end
            default: ;
        endcase

        // Mode advances after the step has used the old field.
        if (ev[3]) begin
            case (mode_q)
                MODE_WAVE:   mode_d = MODE_PERIOD;
                MODE_PERIOD: mode_d = MODE_AMP;
                default:     mode_d = MODE_WAVE;
            endcase
        end

        // Commit snapshots the shadow as registered, not this cycle's edit.
        commit    = ev[0] || (cfg.wrap && pending_q);
        wave_d    = commit ? sh_wave_q : wave_q;
        peri_d    = commit ? sh_peri_q : peri_q;
        amp_d     = commit ? sh_amp_q  : amp_q;
        cfg_upd_d = commit;
        pending_d = ({sh_wave_d, sh_peri_d, sh_amp_d} != {wave_d, peri_d, amp_d});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_WAVE;
            btn_q     <= '0;
            cnt_q     <= '0;
            rep_q     <= 1'b0;
            sh_wave_q <= '0;
            sh_peri_q <= '0;
            sh_amp_q  <= '0;
            wave_q    <= '0;
            peri_q    <= '0;
            amp_q     <= '0;
            cfg_upd_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            btn_q     <= cfg.btn;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            sh_wave_q <= sh_wave_d;
            sh_peri_q <= sh_peri_d;
            sh_amp_q  <= sh_amp_d;
            wave_q    <= wave_d;
            peri_q    <= peri_d;
            amp_q     <= amp_d;
            cfg_upd_q <= cfg_upd_d;
            pending_q <= pending_d;
        end
    end

    assign cfg.wave_sel  = wave_q;
    assign cfg.peri_sel  = peri_q;
    assign cfg.amp_sel   = amp_q;
    assign cfg.cfg_upd   = cfg_upd_q;
    assign cfg.edit_mode = mode_q;
    assign cfg.pending   = pending_q;
endmodule

// File: tb/tb_fg_cfg_ctrl.sv
// Bench for fg_cfg_ctrl: hold-length vector table plus hand sequences, with
// committed configurations checked through a cfg_upd scoreboard.
module tb_fg_cfg_ctrl;
    localparam int unsigned DLY  = 8;
    localparam int unsigned RATE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fg_cfg_ctrl_if cfg_if ();

    fg_cfg_ctrl #(.REPEAT_DLY(DLY), .REPEAT_RATE(RATE), .NUM_PERIOD(4), .NUM_AMP(8)) dut (
        .clk (clk),
        .rst (rst),
        .cfg (cfg_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   hold;
        logic inc;
        logic dec;
        int   exp_amp;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    // Capture every committed configuration as it is announced.
    always @(negedge clk) begin
        if (cfg_if.cfg_upd === 1'b1)
            obs_q.push_back({cfg_if.wave_sel, cfg_if.peri_sel, cfg_if.amp_sel});
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_commit(input int w, input int p, input int a);
        exp_q.push_back({2'(w), 3'(p), 3'(a)});
    endtask

    task automatic drain(input string name);
        logic [7:0] e, o;
        repeat (3) @(negedge clk);
        #1;
        chk({name, " cfg_upd count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                chk({name, " committed cfg"}, int'(o), int'(e));
            end
        end
        obs_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cfg_if.btn = '0;
        cfg_if.wrap = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] b, input logic w, input int n);
        cfg_if.btn = b;
        cfg_if.wrap = w;
        repeat (n) @(negedge clk);
        cfg_if.btn = '0;
        cfg_if.wrap = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{hold: 1,  inc: 1'b1, dec: 1'b0, exp_amp: 1};
        vecs[1] = '{hold: 8,  inc: 1'b1, dec: 1'b0, exp_amp: 1};
        vecs[2] = '{hold: 9,  inc: 1'b1, dec: 1'b0, exp_amp: 2};
        vecs[3] = '{hold: 12, inc: 1'b1, dec: 1'b0, exp_amp: 2};
        vecs[4] = '{hold: 13, inc: 1'b1, dec: 1'b0, exp_amp: 3};
        vecs[5] = '{hold: 17, inc: 1'b1, dec: 1'b0, exp_amp: 4};
        vecs[6] = '{hold: 21, inc: 1'b1, dec: 1'b0, exp_amp: 5};
        vecs[7] = '{hold: 40, inc: 1'b1, dec: 1'b0, exp_amp: 7};
        vecs[8] = '{hold: 30, inc: 1'b1, dec: 1'b1, exp_amp: 0};

        cfg_if.btn = '0;
        cfg_if.wrap = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset wave_sel", int'(cfg_if.wave_sel), 0);
        chk("reset pending", int'(cfg_if.pending), 0);
        chk("reset edit_mode", int'(cfg_if.edit_mode), 0);
        rst = 1'b0;
        @(negedge clk);

        // Period edit wraps 3->0, commit on wrap.
        drive(4'b1000, 1'b0, 1);
        chk("mode period", int'(cfg_if.edit_mode), 1);
        for (int i = 0; i < 5; i++) drive(4'b0010, 1'b0, 1);
        chk("period pending", int'(cfg_if.pending), 1);
        chk("period live before wrap", int'(cfg_if.peri_sel), 0);
        expect_commit(0, 1, 0);
        drive(4'b0000, 1'b1, 1);
        drain("period wrap");
        chk("period live", int'(cfg_if.peri_sel), 1);
        chk("period pending cleared", int'(cfg_if.pending), 0);

        // Amplitude saturates at 7; no wrap means no commit.
        do_reset();
        drive(4'b1000, 1'b0, 1);
        drive(4'b1000, 1'b0, 1);
        chk("mode amp", int'(cfg_if.edit_mode), 2);
        for (int i = 0; i < 10; i++) drive(4'b0010, 1'b0, 1);
        drive(4'b0100, 1'b0, 1);
        chk("amp live unchanged", int'(cfg_if.amp_sel), 0);
        chk("amp pending", int'(cfg_if.pending), 1);
        expect_commit(0, 0, 6);
        drive(4'b0001, 1'b0, 1);
        drain("amp apply");

        // Saturated dec at 0 is a no-op; period dec from 0 wraps to 3.
        do_reset();
        drive(4'b1000, 1'b0, 1);
        drive(4'b1000, 1'b0, 1);
        drive(4'b0100, 1'b0, 1);
        chk("amp dec at 0 pending", int'(cfg_if.pending), 0);
        do_reset();
        drive(4'b1000, 1'b0, 1);
        drive(4'b0100, 1'b0, 1);
        expect_commit(0, 3, 0);
        drive(4'b0001, 1'b0, 1);
        drain("period dec wrap");

        // Auto-repeat table: hold length -> amplitude reached.
        foreach (vecs[i]) begin
            do_reset();
            drive(4'b1000, 1'b0, 1);
            drive(4'b1000, 1'b0, 1);
            drive({1'b0, vecs[i].dec, vecs[i].inc, 1'b0}, 1'b0, vecs[i].hold);
            expect_commit(0, 0, vecs[i].exp_amp);
            drive(4'b0001, 1'b0, 1);
            drain($sformatf("repeat hold %0d", vecs[i].hold));
            chk($sformatf("repeat amp hold %0d", vecs[i].hold), int'(cfg_if.amp_sel), vecs[i].exp_amp);
        end

        // Edit in the same cycle as wrap with pending=0: no commit until next wrap.
        do_reset();
        drive(4'b0010, 1'b1, 1);
        chk("inc+wrap pending", int'(cfg_if.pending), 1);
        chk("inc+wrap live", int'(cfg_if.wave_sel), 0);
        drain("inc+wrap no commit");
        expect_commit(1, 0, 0);
        drive(4'b0000, 1'b1, 1);
        drain("second wrap");
        chk("wave live", int'(cfg_if.wave_sel), 1);
        drive(4'b0000, 1'b1, 1);
        drive(4'b0000, 1'b1, 1);
        drain("idle wraps");

        // Apply and wrap together give a single commit.
        drive(4'b0010, 1'b0, 1);
        expect_commit(2, 0, 0);
        drive(4'b0001, 1'b1, 1);
        drain("apply+wrap");

        // Edit during the commit cycle stays pending for the next wrap.
        expect_commit(2, 0, 0);
        drive(4'b0011, 1'b0, 1);
        drain("apply+inc");
        chk("apply+inc pending", int'(cfg_if.pending), 1);
        expect_commit(3, 0, 0);
        drive(4'b0000, 1'b1, 1);
        drain("apply+inc wrap");

        // Mode and inc together: old field steps, then mode advances.
        do_reset();
        drive(4'b1010, 1'b0, 1);
        chk("mode+inc edit_mode", int'(cfg_if.edit_mode), 1);
        expect_commit(1, 0, 0);
        drive(4'b0001, 1'b0, 1);
        drain("mode+inc apply");

        // Asynchronous reset mid-edit.
        do_reset();
        drive(4'b1000, 1'b0, 1);
        drive(4'b1000, 1'b0, 1);
        drive(4'b0010, 1'b0, 1);
        expect_commit(0, 0, 1);
        drive(4'b0001, 1'b0, 1);
        drain("pre-reset apply");
        drive(4'b0010, 1'b0, 1);
        chk("pre-reset pending", int'(cfg_if.pending), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst amp_sel", int'(cfg_if.amp_sel), 0);
        chk("async rst pending", int'(cfg_if.pending), 0);
        chk("async rst edit_mode", int'(cfg_if.edit_mode), 0);
        @(negedge clk);
        rst = 1'b0;
        drain("post-reset");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
